// File: rtl/pokemon_pkg.sv
//------------------------------------------------------------------------------
// Module   : pokemon_pkg
// Brief    : Shared types and defaults for the overworld/battle encounter path.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package pokemon_pkg;

    typedef logic [2:0] species_t;

    localparam int       NUM_SPECIES_DEFAULT = 5;
    localparam species_t SPECIES_DEFAULT     = 3'b000;

    typedef enum logic [2:0] {
        ARM    = 3'd0,
        WALK   = 3'd1,
        DRAW   = 3'd2,
        REQ    = 3'd3,
        BATTLE = 3'd4
    } enc_state_t;

    // Out-of-range random codes fold onto the default species.
    function automatic species_t species_sanitize(input species_t code, input int num);
        return (int'(code) < num) ? code : SPECIES_DEFAULT;
    endfunction

endpackage

`default_nettype wire

// File: rtl/encounter_ctrl.sv
//------------------------------------------------------------------------------
// Module   : encounter_ctrl
// Brief    : Wild-encounter controller: counts grass steps, draws a species
//            from the random source and hands it to the battle FSM via req/ack.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module encounter_ctrl
    import pokemon_pkg::*;
#(
    parameter int STEP_THRESH = 4,
    parameter int RAND_HOLD   = 3,
    parameter int NUM_SPECIES = NUM_SPECIES_DEFAULT
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       step,
    input  logic       in_grass,
    input  logic [2:0] poke_num,
    output logic       rand_en,
    output logic       battle_req,
    output logic [2:0] battle_species,
    input  logic       battle_ack,
    input  logic       battle_done,
    output logic       busy
);

    localparam int         CNT_W     = $clog2(STEP_THRESH + NUM_SPECIES + 1);
    localparam logic [3:0] HOLD_LAST = 4'(RAND_HOLD - 1);

    enc_state_t       state_q,    state_d;
    logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
    logic [3:0]       hold_cnt_q, hold_cnt_d;
    species_t         extra_q,    extra_d;
    species_t         species_q,  species_d;
    logic             rand_en_q;
    logic             battle_req_q;
    logic             busy_q;
    logic [CNT_W-1:0] target;

    assign target = CNT_W'(STEP_THRESH) + CNT_W'(extra_q);

    always_comb begin
        state_d    = state_q;
        step_cnt_d = step_cnt_q;
        hold_cnt_d = hold_cnt_q;
        extra_d    = extra_q;
        species_d  = species_q;
        case (state_q)
            ARM: begin
                extra_d    = species_sanitize(poke_num, NUM_SPECIES);
                step_cnt_d = '0;
                state_d    = WALK;
            end
            WALK: begin
                if (step) begin
                    if (in_grass) begin
                        if (step_cnt_q + CNT_W'(1) == target) begin
                            hold_cnt_d = 4'd0;
                            state_d    = DRAW;
                        end else begin
                            step_cnt_d = step_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        step_cnt_d = '0;
                    end
                end
            end
            DRAW: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    species_d = species_sanitize(poke_num, NUM_SPECIES);
                    state_d   = REQ;
                end else begin
                    hold_cnt_d = hold_cnt_q + 4'd1;
                end
            end
            REQ: begin
                if (battle_ack) begin
                    state_d = BATTLE;
                end
            end
            BATTLE: begin
                if (battle_done) begin
                    state_d = ARM;
                end
            end
            default: state_d = ARM;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q      <= ARM;
            step_cnt_q   <= '0;
            hold_cnt_q   <= 4'd0;
            extra_q      <= SPECIES_DEFAULT;
            species_q    <= SPECIES_DEFAULT;
            rand_en_q    <= 1'b0;
            battle_req_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_cnt_q   <= step_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            extra_q      <= extra_d;
            species_q    <= species_d;
            rand_en_q    <= (state_d == WALK) || (state_d == DRAW);
            battle_req_q <= (state_d == REQ);
            busy_q       <= (state_d == REQ) || (state_d == BATTLE);
        end
    end

    assign rand_en        = rand_en_q;
    assign battle_req     = battle_req_q;
    assign battle_species = species_q;
    assign busy           = busy_q;

endmodule

`default_nettype wire
